// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational ALU: arbitrates, issues one
// operation at a time and returns the captured result on the winner's response channel.
module alu_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        req0_valid_i,
    output logic        req0_ready_o,
    input  logic [4:0]  req0_ctrl_i,
    input  logic [31:0] req0_a_i,
    input  logic [31:0] req0_b_i,

    input  logic        req1_valid_i,
    output logic        req1_ready_o,
    input  logic [4:0]  req1_ctrl_i,
    input  logic [31:0] req1_a_i,
    input  logic [31:0] req1_b_i,

    output logic        rsp0_valid_o,
    input  logic        rsp0_ready_i,
    output logic [31:0] rsp0_result_o,
    output logic [2:0]  rsp0_flags_o,

    output logic        rsp1_valid_o,
    input  logic        rsp1_ready_i,
    output logic [31:0] rsp1_result_o,
    output logic [2:0]  rsp1_flags_o,

    output logic [4:0]  alu_ctrl_o,
    output logic [31:0] alu_a_o,
    output logic [31:0] alu_b_o,
    input  logic [31:0] alu_result_i,
    input  logic [2:0]  alu_flags_i,

    output logic        busy_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_last_grant;
    logic        r_grant;
    logic [4:0]  r_ctrl;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_result;
    logic [2:0]  r_flags;

    logic w_grant;
    logic w_idle;
    logic w_req0_ready;
    logic w_req1_ready;
    logic w_accept;
    logic w_rsp_ready;

    always_comb begin
        // NOTE: default first so every path assigns w_grant and no latch is inferred.
        w_grant = 1'b0;
        case ({req1_valid_i, req0_valid_i})
            2'b10:   w_grant = 1'b1;
            2'b11:   w_grant = RR_EN ? ~r_last_grant : 1'b0;
            default: w_grant = 1'b0;
        endcase
    end

    // IDLE is also the reset state, so ready must be masked by rst_i explicitly.
    assign w_idle       = (r_state == IDLE) && !rst_i;
    assign w_req0_ready = w_idle && req0_valid_i && !w_grant;
    assign w_req1_ready = w_idle && req1_valid_i && w_grant;
    assign w_accept     = w_req0_ready || w_req1_ready;
    assign w_rsp_ready  = r_grant ? rsp1_ready_i : rsp0_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_grant      <= 1'b0;
            r_ctrl       <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_result     <= '0;
            r_flags      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_grant      <= w_grant;
                        r_last_grant <= w_grant;
                        r_ctrl       <= w_grant ? req1_ctrl_i : req0_ctrl_i;
                        r_a          <= w_grant ? req1_a_i    : req0_a_i;
                        r_b          <= w_grant ? req1_b_i    : req0_b_i;
                        r_state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_result <= alu_result_i;
                    r_flags  <= alu_flags_i;
                    // Operand registers double as the ALU drive, so clear them once issued.
                    r_ctrl   <= '0;
                    r_a      <= '0;
                    r_b      <= '0;
                    r_state  <= RESP;
                end
                RESP: begin
                    if (w_rsp_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req0_ready_o  = w_req0_ready;
    assign req1_ready_o  = w_req1_ready;

    assign alu_ctrl_o    = r_ctrl;
    assign alu_a_o       = r_a;
    assign alu_b_o       = r_b;

    assign rsp0_valid_o  = (r_state == RESP) && !r_grant;
    assign rsp1_valid_o  = (r_state == RESP) && r_grant;
    assign rsp0_result_o = r_result;
    assign rsp1_result_o = r_result;
    assign rsp0_flags_o  = r_flags;
    assign rsp1_flags_o  = r_flags;

    assign busy_o        = (r_state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: randomized and directed requests against a
// rule-level grant/latency model, plus a fixed-priority instance.
module tb_alu_arbiter;

    typedef struct packed {
        logic [31:0] res;
        logic [2:0]  flg;
    } alu_out_t;

    typedef struct {
        logic        ch;
        logic [31:0] res;
        logic [2:0]  flg;
        int          acc_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Round-robin instance signals
    logic [1:0]        req_valid, req_ready, rsp_valid, rsp_ready;
    logic [1:0][4:0]   req_ctrl;
    logic [1:0][31:0]  req_a, req_b, rsp_result;
    logic [1:0][2:0]   rsp_flags;
    logic [4:0]        alu_ctrl;
    logic [31:0]       alu_a, alu_b, alu_result;
    logic [2:0]        alu_flags;
    logic              busy;
    logic              flag_ovr_en;
    logic [2:0]        flag_ovr;
    alu_out_t          alu_out;
    logic [143:0]      main_outs;

    // Fixed-priority instance signals
    logic [1:0]        fp_ready, fp_rspv;
    logic [1:0][31:0]  fp_res;
    logic [1:0][2:0]   fp_flg;
    logic [4:0]        fp_actrl;
    logic [31:0]       fp_aa, fp_ab;
    logic              fp_busy;
    alu_out_t          fp_alu;
    logic [143:0]      fp_outs;

    int   n_checks = 0;
    int   n_pass   = 0;
    bit   rdy_force = 1'b1;
    logic last_served = 1'b1;
    exp_t sb_q[$];

    function automatic alu_out_t ref_alu(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
        alu_out_t o;
        case (c)
            5'd0:    o.res = a + b;
            5'd1:    o.res = a - b;
            5'd2:    o.res = a & b;
            5'd3:    o.res = a | b;
            5'd4:    o.res = a ^ b;
            5'd5:    o.res = a << b[4:0];
            5'd6:    o.res = a >> b[4:0];
            default: o.res = a + b + {27'd0, c};
        endcase
        o.flg = {o.res == 32'd0, $signed(a) > $signed(b), a > b};
        return o;
    endfunction

    // Shared ALU stubs seen by each instance
    assign alu_out    = ref_alu(alu_ctrl, alu_a, alu_b);
    assign alu_result = alu_out.res;
    assign alu_flags  = flag_ovr_en ? flag_ovr : alu_out.flg;
    assign fp_alu     = ref_alu(fp_actrl, fp_aa, fp_ab);

    assign main_outs = {req_ready, rsp_valid, busy, alu_ctrl, alu_a, alu_b, rsp_result, rsp_flags};
    assign fp_outs   = {fp_ready, fp_rspv, fp_busy, fp_actrl, fp_aa, fp_ab, fp_res, fp_flg};

    alu_arbiter #(.RR_EN(1'b1)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req0_valid_i (req_valid[0]),
        .req0_ready_o (req_ready[0]),
        .req0_ctrl_i  (req_ctrl[0]),
        .req0_a_i     (req_a[0]),
        .req0_b_i     (req_b[0]),
        .req1_valid_i (req_valid[1]),
        .req1_ready_o (req_ready[1]),
        .req1_ctrl_i  (req_ctrl[1]),
        .req1_a_i     (req_a[1]),
        .req1_b_i     (req_b[1]),
        .rsp0_valid_o (rsp_valid[0]),
        .rsp0_ready_i (rsp_ready[0]),
        .rsp0_result_o(rsp_result[0]),
        .rsp0_flags_o (rsp_flags[0]),
        .rsp1_valid_o (rsp_valid[1]),
        .rsp1_ready_i (rsp_ready[1]),
        .rsp1_result_o(rsp_result[1]),
        .rsp1_flags_o (rsp_flags[1]),
        .alu_ctrl_o   (alu_ctrl),
        .alu_a_o      (alu_a),
        .alu_b_o      (alu_b),
        .alu_result_i (alu_result),
        .alu_flags_i  (alu_flags),
        .busy_o       (busy)
    );

    alu_arbiter #(.RR_EN(1'b0)) dut_fp (
        .clk_i        (clk),
        .rst_i        (rst),
        .req0_valid_i (1'b1),
        .req0_ready_o (fp_ready[0]),
        .req0_ctrl_i  (5'd0),
        .req0_a_i     (32'd100),
        .req0_b_i     (32'd23),
        .req1_valid_i (1'b1),
        .req1_ready_o (fp_ready[1]),
        .req1_ctrl_i  (5'd1),
        .req1_a_i     (32'd9),
        .req1_b_i     (32'd4),
        .rsp0_valid_o (fp_rspv[0]),
        .rsp0_ready_i (1'b1),
        .rsp0_result_o(fp_res[0]),
        .rsp0_flags_o (fp_flg[0]),
        .rsp1_valid_o (fp_rspv[1]),
        .rsp1_ready_i (1'b1),
        .rsp1_result_o(fp_res[1]),
        .rsp1_flags_o (fp_flg[1]),
        .alu_ctrl_o   (fp_actrl),
        .alu_a_o      (fp_aa),
        .alu_b_o      (fp_ab),
        .alu_result_i (fp_alu.res),
        .alu_flags_i  (fp_alu.flg),
        .busy_o       (fp_busy)
    );

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: event missing or illegal (cycle %0d)", name, cyc);
    endtask

    // Grant rule: lone requester wins; on a tie the one not served last wins.
    function automatic logic predict(input logic [1:0] v);
        if (v == 2'b11) return ~last_served;
        return v[1] && !v[0];
    endfunction

    task automatic raise(input int ch, input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
        req_ctrl[ch]  = c;
        req_a[ch]     = a;
        req_b[ch]     = b;
        req_valid[ch] = 1'b1;
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic step(output bit acc, output bit ch);
        logic [1:0]  rdy;
        logic [4:0]  c;
        logic [31:0] a, b;
        alu_out_t    r;
        exp_t        e;
        acc = 1'b0;
        ch  = 1'b0;
        c   = '0;
        a   = '0;
        b   = '0;
        #1;
        rdy = req_ready;
        if (rdy != 2'b00) begin
            check("ready_only_when_valid", 160'(rdy & ~req_valid), 160'(0));
            if (rdy == 2'b11) begin
                fail_now("double_ready");
            end else begin
                ch = rdy[1];
                check("grant", 160'(ch), 160'(predict(req_valid)));
                acc = 1'b1;
                c = req_ctrl[ch];
                a = req_a[ch];
                b = req_b[ch];
                r = ref_alu(c, a, b);
                e.ch      = ch;
                e.res     = r.res;
                e.flg     = flag_ovr_en ? flag_ovr : r.flg;
                e.acc_cyc = cyc;
                sb_q.push_back(e);
                last_served = ch;
            end
        end
        @(posedge clk);
        #1;
        if (acc) begin
            req_valid[ch] = 1'b0;
            check("alu_drive_issue", 160'({alu_ctrl, alu_a, alu_b}), 160'({c, a, b}));
            check("busy_issue", 160'(busy), 160'(1));
        end
        @(negedge clk);
    endtask

    task automatic drain();
        int g;
        bit acc, ch;
        g = 0;
        while ((req_valid != 2'b00 || sb_q.size() != 0 || busy) && g < 60) begin
            step(acc, ch);
            g++;
        end
        if (g >= 60) fail_now("drain_timeout");
    endtask

    // Response-channel randomizer
    initial begin
        forever begin
            @(negedge clk);
            if (!rdy_force) rsp_ready = 2'($urandom);
        end
    end

    // Monitor: pops the scoreboard whenever a response appears
    bit   mon_holding = 1'b0;
    exp_t mon_cur;
    int   mon_wait = 0;
    logic mon_ch;
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                mon_holding = 1'b0;
                mon_wait    = 0;
            end else if (rsp_valid != 2'b00) begin
                mon_wait = 0;
                mon_ch   = rsp_valid[1];
                if (rsp_valid == 2'b11) begin
                    fail_now("rsp_both_valid");
                end else if (!mon_holding) begin
                    if (sb_q.size() == 0) begin
                        fail_now("rsp_unexpected");
                    end else begin
                        mon_cur     = sb_q.pop_front();
                        mon_holding = 1'b1;
                        check("rsp_channel", 160'(mon_ch), 160'(mon_cur.ch));
                        check("rsp_latency", 160'(cyc), 160'(mon_cur.acc_cyc + 2));
                        check("rsp_result", 160'(rsp_result[mon_ch]), 160'(mon_cur.res));
                        check("rsp_flags", 160'(rsp_flags[mon_ch]), 160'(mon_cur.flg));
                    end
                end else begin
                    check("rsp_hold_channel", 160'(mon_ch), 160'(mon_cur.ch));
                    check("rsp_hold_result", 160'(rsp_result[mon_ch]), 160'(mon_cur.res));
                    check("rsp_hold_flags", 160'(rsp_flags[mon_ch]), 160'(mon_cur.flg));
                end
                check("no_ready_in_resp", 160'(req_ready), 160'(0));
                check("busy_resp", 160'(busy), 160'(1));
                check("alu_zero_resp", 160'({alu_ctrl, alu_a, alu_b}), 160'(0));
                if (rsp_ready[mon_ch]) mon_holding = 1'b0;
            end else begin
                if (mon_holding) begin
                    fail_now("rsp_dropped_early");
                    mon_holding = 1'b0;
                end
                if (!busy) check("alu_zero_idle", 160'({alu_ctrl, alu_a, alu_b}), 160'(0));
                if (sb_q.size() != 0) begin
                    mon_wait++;
                    if (mon_wait > 6) begin
                        fail_now("rsp_timeout");
                        void'(sb_q.pop_front());
                        mon_wait = 0;
                    end
                end
            end
        end
    end

    bit          m_acc, m_ch;
    int          m_n, m_guard, stall, fp_last, fp_nacc;
    logic [1:0]  m_seq;
    logic [31:0] ra, rb;
    alu_out_t    fp_exp;

    initial begin
        req_valid   = 2'b00;
        req_ctrl    = '0;
        req_a       = '0;
        req_b       = '0;
        rsp_ready   = 2'b00;
        flag_ovr_en = 1'b0;
        flag_ovr    = 3'b000;
        m_seq       = 2'b00;

        // Reset with both requesters already valid: nothing may leak out.
        raise(0, 5'd2, 32'hF0F0_1234, 32'h0FF0_FFFF);
        raise(1, 5'd4, 32'h1357_9BDF, 32'h2468_ACE0);
        rsp_ready = 2'b11;
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs_low", 160'(main_outs), 160'(0));
        check("reset_fp_outputs_low", 160'(fp_outs), 160'(0));
        @(negedge clk);
        rst = 1'b0;

        // Tie after reset: requester 0 first, then requester 1.
        m_n = 0;
        m_guard = 0;
        while (m_n < 2 && m_guard < 20) begin
            step(m_acc, m_ch);
            if (m_acc) begin
                m_seq[m_n] = m_ch;
                m_n++;
            end
            m_guard++;
        end
        if (m_n < 2) fail_now("tie_timeout");
        else begin
            check("tie_first_grant", 160'(m_seq[0]), 160'(0));
            check("tie_second_grant", 160'(m_seq[1]), 160'(1));
        end
        drain();

        // Single add 5+7, then sub 3-3 with injected flags 110.
        rsp_ready = 2'b01;
        raise(0, 5'd0, 32'd5, 32'd7);
        drain();
        flag_ovr_en = 1'b1;
        flag_ovr    = 3'b110;
        raise(0, 5'd1, 32'd3, 32'd3);
        drain();
        flag_ovr_en = 1'b0;

        // Backpressure on channel 0 for four cycles with an all-ones result.
        rsp_ready = 2'b00;
        raise(0, 5'd3, 32'hFFFF_FFFF, 32'h0000_0000);
        m_acc = 1'b0;
        m_guard = 0;
        while (!m_acc && m_guard < 20) begin
            step(m_acc, m_ch);
            m_guard++;
        end
        if (!m_acc) fail_now("bp_accept_timeout");
        raise(1, 5'd20, 32'h0000_00FF, 32'h0000_0F0F);
        step(m_acc, m_ch);
        repeat (4) begin
            #3;
            check("bp_valid", 160'(rsp_valid), 160'(2'b01));
            check("bp_result", 160'(rsp_result[0]), 160'(32'hFFFF_FFFF));
            check("bp_ready_low", 160'(req_ready), 160'(0));
            check("bp_busy", 160'(busy), 160'(1));
            step(m_acc, m_ch);
        end
        rsp_ready = 2'b11;
        @(posedge clk);
        #1;
        check("bp_release_idle", 160'(busy), 160'(0));
        @(negedge clk);
        drain();

        // Randomized traffic with random response backpressure and withdrawals.
        rdy_force = 1'b0;
        stall = 0;
        repeat (300) begin
            for (int i = 0; i < 2; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    ra = $urandom;
                    rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
                    raise(i, 5'($urandom_range(0, 31)), ra, rb);
                end else if (req_valid[i] && $urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            step(m_acc, m_ch);
            if (req_valid != 2'b00 && !m_acc) stall++;
            else stall = 0;
            if (stall > 40) begin
                fail_now("random_stall");
                req_valid = 2'b00;
                stall = 0;
            end
        end
        rdy_force = 1'b1;
        rsp_ready = 2'b11;
        drain();

        // Asynchronous reset while a request sits in ISSUE.
        raise(0, 5'd0, 32'd40, 32'd2);
        m_acc = 1'b0;
        m_guard = 0;
        while (!m_acc && m_guard < 20) begin
            step(m_acc, m_ch);
            m_guard++;
        end
        if (!m_acc) fail_now("rst_accept_timeout");
        rst = 1'b1;
        sb_q.delete();
        last_served = 1'b1;
        raise(0, 5'd4, 32'hAAAA_0000, 32'h0000_5555);
        raise(1, 5'd2, 32'h1234_5678, 32'hFFFF_0000);
        #1;
        check("rst_mid_issue_outputs_low", 160'(main_outs), 160'(0));
        repeat (2) @(negedge clk);
        #1;
        check("rst_held_outputs_low", 160'(main_outs), 160'(0));
        @(negedge clk);
        rst = 1'b0;
        step(m_acc, m_ch);
        check("tie_after_reset_accept", 160'(m_acc), 160'(1));
        check("tie_after_reset_grant", 160'(m_ch), 160'(0));
        drain();

        // Fixed-priority instance with both requesters valid all the time.
        fp_last = -1;
        fp_nacc = 0;
        fp_exp  = ref_alu(5'd0, 32'd100, 32'd23);
        repeat (30) begin
            @(negedge clk);
            #1;
            check("fp_req1_never_ready", 160'(fp_ready[1]), 160'(0));
            check("fp_rsp1_never_valid", 160'(fp_rspv[1]), 160'(0));
            if (fp_ready[0]) begin
                if (fp_last >= 0) check("fp_issue_interval", 160'(cyc - fp_last), 160'(3));
                fp_last = cyc;
                fp_nacc++;
            end
            if (fp_rspv[0]) check("fp_rsp0_result", 160'({fp_flg[0], fp_res[0]}), 160'({fp_exp.flg, fp_exp.res}));
        end
        check("fp_accept_count", 160'(fp_nacc), 160'(10));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter RR_EN, default 1, meaning 1 = round-robin grant and 0 = fixed priority to requester 0.
REQ-002 SHALL have clock and reset ports: clk_i in 1, rising-edge clock; rst_i in 1, reset (one clock; reset is asynchronous and active-high).
REQ-003 SHALL have req0_valid_i in 1 (request 0 valid) and req0_ready_o out 1 (request 0 accepted).
REQ-004 SHALL have req0_ctrl_i in 5, req0_a_i in 32, req0_b_i in 32: request 0 ALU opcode and operands.
REQ-005 SHALL have req1_valid_i, req1_ready_o, req1_ctrl_i, req1_a_i, req1_b_i: the same as requester 0, for requester 1.
REQ-006 SHALL have rsp0_valid_o out 1, rsp0_ready_i in 1, rsp0_result_o out 32, rsp0_flags_o out 3: response channel 0.
REQ-007 SHALL have rsp1_valid_o, rsp1_ready_i, rsp1_result_o, rsp1_flags_o: the same as channel 0, for requester 1.
REQ-008 SHALL have alu_ctrl_o out 5, alu_a_o out 32, alu_b_o out 32: drive to the shared ALU.
REQ-009 SHALL have alu_result_i in 32 and alu_flags_i in 3: shared ALU result and {zero, gt, gtu} flags.
REQ-010 SHALL have busy_o out 1, high in any state other than IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, ISSUE and RESP.
REQ-012 SHALL assert reqN_ready_o only in IDLE, for the granted requester only, combinationally from the valid inputs.
REQ-013 SHALL accept a request on a clock edge where reqN_valid_i and reqN_ready_o are both high.
REQ-014 SHALL, on acceptance, register ctrl, a, b and the grant index, then move IDLE -> ISSUE.
REQ-015 SHALL, in ISSUE, drive alu_ctrl_o, alu_a_o and alu_b_o from those registers.
REQ-016 SHALL, at the end of ISSUE, capture alu_result_i and alu_flags_i into response registers and move ISSUE -> RESP.
REQ-017 SHALL, in RESP, hold rspN_valid_o high for the granted index only, with result and flags stable.
REQ-018 SHALL move RESP -> IDLE on the edge where rspN_ready_i is high.
REQ-019 SHALL NOT accept a new request in the same cycle as that response handshake.
REQ-020 SHALL give accept-to-response latency of exactly 2 cycles: accept at edge k, rsp_valid high from edge k+2.
REQ-021 SHALL give a minimum issue interval of 3 cycles.
REQ-022 SHALL grant the only valid requester when one requester is valid.
REQ-023 SHALL, with both valid, RR_EN=1: grant the requester not served by the most recent accepted request; last_grant toggles only on acceptance.
REQ-024 SHALL, with both valid, RR_EN=0: always grant requester 0.
REQ-025 SHALL drive alu_ctrl_o=0, alu_a_o=0, alu_b_o=0 outside ISSUE.
REQ-026 SHALL pass opcode values 13..31 through unmodified.
REQ-027 SHALL ignore rspN_ready_i outside RESP, and ignore the ready of the non-granted channel.
REQ-028 SHALL let a requester deassert valid without acceptance without effect; grant is re-evaluated each IDLE cycle.

Reset
REQ-029 SHALL, on rst_i high (asynchronous, any state including ISSUE/RESP): state=IDLE, last_grant=1 (requester 0 wins first tie), all operand/result registers=0.
REQ-030 SHALL hold all outputs low while rst_i is high: ready, valid, busy, alu_* and rsp_*.
REQ-031 SHALL discard any in-flight request on reset, with no response issued.
REQ-032 SHALL leave IDLE no earlier than the first rising edge after rst_i falls.

Verification
REQ-033 SHALL cover: single request, req0 ctrl=0, a=5, b=7, rsp0_ready=1 -> alu_ctrl_o=0/a=5/b=7 during ISSUE, then rsp0_valid at k+2 with result=12, flags=000.
REQ-034 SHALL cover: simultaneous valid, RR_EN=1, both held for 2 transactions -> grants 0 then 1, with rsp1 result of req1 operands and rsp0 never valid for the second.
REQ-035 SHALL cover: RR_EN=0, both valid continuously -> req1_ready_o never asserted, req0 serviced every 3 cycles.
REQ-036 SHALL cover: backpressure, rsp0_ready=0 for 4 cycles, ALU result 0xFFFF_FFFF -> rsp0_valid held with stable 0xFFFF_FFFF, req*_ready low, busy_o high; release -> IDLE next edge.
REQ-037 SHALL cover: rst_i asserted mid-ISSUE between clock edges -> all outputs 0 immediately, no response after release, and the next tie grants requester 0.
REQ-038 SHALL cover: sub with a=3, b=3 and flags_i=110 -> rsp flags_o=110, result=0.
